// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate-library self-test sequencer.
//   - Bit positions of the seven gate outputs on the gate_in bus.
//   - FSM state encoding.
//   - exp_gates: truth-table model of the gate block for one {a,b} pair.
//   - popcount7: number of set bits in a 7-bit mismatch vector.
package gate_sweep_pkg;

  localparam int unsigned G_AND     = 0;
  localparam int unsigned G_OR      = 1;
  localparam int unsigned G_NOT_A   = 2;
  localparam int unsigned G_NAND    = 3;
  localparam int unsigned G_NOR     = 4;
  localparam int unsigned G_XOR     = 5;
  localparam int unsigned G_XNOR    = 6;
  localparam int unsigned NUM_GATES = 7;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SAMPLE
  } state_t;

  function automatic logic [NUM_GATES-1:0] exp_gates(input logic a, input logic b);
    logic [NUM_GATES-1:0] g;
    g          = '0;
    g[G_AND]   = a & b;
    g[G_OR]    = a | b;
    g[G_NOT_A] = ~a;
    g[G_NAND]  = ~(a & b);
    g[G_NOR]   = ~(a | b);
    g[G_XOR]   = a ^ b;
    g[G_XNOR]  = ~(a ^ b);
    return g;
  endfunction

  function automatic logic [2:0] popcount7(input logic [NUM_GATES-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int unsigned i = 0; i < NUM_GATES; i++) begin
      c = c + 3'(v[i]);
    end
    return c;
  endfunction

endpackage

// File: rtl/gate_sweep_checker.sv
// Self-test sequencer for the MUX-built logic-gate block.
// Drives all four {a,b} combinations (PASSES times), holds each for
// SETTLE_CYCLES, samples the seven gate outputs and compares them with the
// truth-table model, accumulating sticky per-gate flags and a saturating
// count of mismatching bits.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   start      request a sweep (accepted only in IDLE)
//   a_out      operand a to gate block
//   b_out      operand b to gate block
//   gate_in    {xnor,xor,nor,nand,not_a,or,and} from the gate block
//   busy       high while a sweep runs
//   done       one-cycle pulse when results become valid
//   pass       1 when the last finished sweep saw no mismatch
//   err_mask   sticky per-gate mismatch flags (gate_in bit order)
//   err_count  total mismatching bits, saturating
module gate_sweep_checker
  import gate_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a_out,
  output logic             b_out,
  input  logic [6:0]       gate_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [6:0]       err_mask,
  output logic [CNT_W-1:0] err_count
);

  localparam int unsigned SC_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int unsigned PC_W = (PASSES > 1) ? $clog2(PASSES) : 1;

  localparam logic [SC_W-1:0]    SETTLE_LAST = SC_W'(SETTLE_CYCLES - 1);
  localparam logic [PC_W-1:0]    PASS_LAST   = PC_W'(PASSES - 1);
  localparam logic [CNT_W+2:0]   CNT_MAX     = {3'b000, {CNT_W{1'b1}}};

  state_t            state, state_nxt;
  logic [1:0]        vec_idx, vec_nxt, vec_inc;
  logic [SC_W-1:0]   settle_cnt, settle_nxt;
  logic [PC_W-1:0]   pass_cnt, pass_cnt_nxt;
  logic              a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt;
  logic [6:0]        mask_nxt, mism;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [CNT_W+2:0]  sum;

  always_comb begin
    state_nxt    = state;
    vec_nxt      = vec_idx;
    settle_nxt   = settle_cnt;
    pass_cnt_nxt = pass_cnt;
    a_nxt        = a_out;
    b_nxt        = b_out;
    busy_nxt     = busy;
    done_nxt     = 1'b0;
    pass_nxt     = pass;
    mask_nxt     = err_mask;
    cnt_nxt      = err_count;
    vec_inc      = vec_idx + 2'd1;
    mism         = gate_in ^ exp_gates(a_out, b_out);
    // Three guard bits keep the 7-bit increment from wrapping before the clamp.
    sum          = {3'b000, err_count} + (CNT_W+3)'(popcount7(mism));

    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = DRIVE;
          busy_nxt     = 1'b1;
          vec_nxt      = '0;
          settle_nxt   = '0;
          pass_cnt_nxt = '0;
          pass_nxt     = 1'b0;
          mask_nxt     = '0;
          cnt_nxt      = '0;
          a_nxt        = 1'b0;
          b_nxt        = 1'b0;
        end
      end
      DRIVE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt  = SAMPLE;
          settle_nxt = '0;
        end else begin
          settle_nxt = settle_cnt + SC_W'(1);
        end
      end
      SAMPLE: begin
        mask_nxt = err_mask | mism;
        cnt_nxt  = (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum[CNT_W-1:0];
        if (vec_idx != 2'd3) begin
          state_nxt = DRIVE;
          vec_nxt   = vec_inc;
          a_nxt     = vec_inc[1];
          b_nxt     = vec_inc[0];
        end else if (pass_cnt != PASS_LAST) begin
          state_nxt    = DRIVE;
          vec_nxt      = '0;
          pass_cnt_nxt = pass_cnt + PC_W'(1);
          a_nxt        = 1'b0;
          b_nxt        = 1'b0;
        end else begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pass_nxt  = ((err_mask | mism) == 7'd0);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vec_idx    <= '0;
      settle_cnt <= '0;
      pass_cnt   <= '0;
      a_out      <= 1'b0;
      b_out      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_mask   <= '0;
      err_count  <= '0;
    end else begin
      state      <= state_nxt;
      vec_idx    <= vec_nxt;
      settle_cnt <= settle_nxt;
      pass_cnt   <= pass_cnt_nxt;
      a_out      <= a_nxt;
      b_out      <= b_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_mask   <= mask_nxt;
      err_count  <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: three instances (S1/P1/W8, S1/P2/W3,
// S2/P1/W8), each fed by a behavioural gate block with injectable faults.
module tb_gate_sweep_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_v [3];
  logic       a_v     [3];
  logic       b_v     [3];
  logic       busy_v  [3];
  logic       done_v  [3];
  logic       pass_v  [3];
  logic [6:0] mask_v  [3];
  logic [7:0] cnt_v   [3];
  logic [6:0] gin_v   [3];
  logic [6:0] flip_v  [3];
  logic [6:0] s0_v    [3];
  logic [6:0] s1_v    [3];
  logic [7:0] cnt0, cnt2;
  logic [2:0] cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Reference truth of each gate, expressed as boolean statements.
  function automatic logic [6:0] good_gates(input logic a, input logic b);
    logic [6:0] g;
    g[0] = a && b;
    g[1] = a || b;
    g[2] = !a;
    g[3] = !(a && b);
    g[4] = !(a || b);
    g[5] = (a != b);
    g[6] = (a == b);
    return g;
  endfunction

  function automatic logic [6:0] gate_block(input logic a, input logic b, input logic [6:0] flip,
                                            input logic [6:0] s0, input logic [6:0] s1);
    return ((good_gates(a, b) ^ flip) & ~s0) | s1;
  endfunction

  assign gin_v[0] = gate_block(a_v[0], b_v[0], flip_v[0], s0_v[0], s1_v[0]);
  assign gin_v[1] = gate_block(a_v[1], b_v[1], flip_v[1], s0_v[1], s1_v[1]);
  assign gin_v[2] = gate_block(a_v[2], b_v[2], flip_v[2], s0_v[2], s1_v[2]);
  assign cnt_v[0] = cnt0;
  assign cnt_v[1] = {5'b00000, cnt1};
  assign cnt_v[2] = cnt2;

  gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(1), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start_v[0]), .a_out(a_v[0]), .b_out(b_v[0]),
    .gate_in(gin_v[0]), .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
    .err_mask(mask_v[0]), .err_count(cnt0));

  gate_sweep_checker #(.SETTLE_CYCLES(1), .PASSES(2), .CNT_W(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_v[1]), .a_out(a_v[1]), .b_out(b_v[1]),
    .gate_in(gin_v[1]), .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
    .err_mask(mask_v[1]), .err_count(cnt1));

  gate_sweep_checker #(.SETTLE_CYCLES(2), .PASSES(1), .CNT_W(8)) dut_c (
    .clk(clk), .rst(rst), .start(start_v[2]), .a_out(a_v[2]), .b_out(b_v[2]),
    .gate_in(gin_v[2]), .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
    .err_mask(mask_v[2]), .err_count(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected sticky mask and saturating count for one full run.
  task automatic model(input int d, input int passes, input int cntmax,
                       output logic [6:0] emask, output int ecnt);
    logic [6:0] diff;
    int ones;
    emask = '0;
    ecnt  = 0;
    for (int p = 0; p < passes; p++) begin
      for (int v = 0; v < 4; v++) begin
        diff  = good_gates(v / 2 == 1, v % 2 == 1) ^
                gate_block(v / 2 == 1, v % 2 == 1, flip_v[d], s0_v[d], s1_v[d]);
        emask = emask | diff;
        ones  = 0;
        for (int i = 0; i < 7; i++) ones += int'(diff[i]);
        ecnt  = (ecnt + ones > cntmax) ? cntmax : ecnt + ones;
      end
    end
  endtask

  task automatic check_idle_zero(input string tag, input int d);
    check({tag, "_busy"}, busy_v[d], 0);
    check({tag, "_done"}, done_v[d], 0);
    check({tag, "_pass"}, pass_v[d], 0);
    check({tag, "_mask"}, mask_v[d], 0);
    check({tag, "_cnt"},  cnt_v[d],  0);
    check({tag, "_ab"},   {a_v[d], b_v[d]}, 0);
  endtask

  // One started sweep; poke_at >= 0 re-pulses start that many cycles in.
  task automatic run_sweep(input string tag, input int d, input int settle, input int passes,
                           input int cntmax, input int poke_at);
    logic [6:0] emask;
    int ecnt;
    int k;
    model(d, passes, cntmax, emask, ecnt);
    @(negedge clk) start_v[d] = 1'b1;
    @(negedge clk) start_v[d] = 1'b0;
    k = 0;
    while (busy_v[d] && k < 200) begin
      check({tag, "_ab_seq"}, {a_v[d], b_v[d]}, (k / (settle + 1)) % 4);
      check({tag, "_done_while_busy"}, done_v[d], 0);
      start_v[d] = (k == poke_at);
      k++;
      @(negedge clk);
    end
    start_v[d] = 1'b0;
    check({tag, "_busy_len"}, k, 4 * passes * (settle + 1));
    check({tag, "_done"}, done_v[d], 1);
    check({tag, "_pass"}, pass_v[d], (emask == 7'd0));
    check({tag, "_mask"}, mask_v[d], emask);
    check({tag, "_cnt"},  cnt_v[d],  ecnt);
    check({tag, "_ab_hold"}, {a_v[d], b_v[d]}, 2'b11);
    @(negedge clk);
    check({tag, "_done_pulse"}, done_v[d], 0);
    check({tag, "_no_restart"}, busy_v[d], 0);
    check({tag, "_mask_hold"}, mask_v[d], emask);
    check({tag, "_cnt_hold"},  cnt_v[d],  ecnt);
  endtask

  task automatic wait_idle(input int d);
    int k;
    k = 0;
    while (busy_v[d] && k < 200) begin
      k++;
      @(negedge clk);
    end
    check("wait_idle_bound", k < 200, 1);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0;
      flip_v[i]  = '0;
      s0_v[i]    = '0;
      s1_v[i]    = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset_a", 0);
    check_idle_zero("reset_b", 1);
    check_idle_zero("reset_c", 2);

    // Healthy gate block.
    run_sweep("healthy", 0, 1, 1, 255, -1);

    // xor output stuck at 0.
    s0_v[0] = 7'b0100000;
    run_sweep("xor_stuck0", 0, 1, 1, 255, -1);
    s0_v[0] = '0;

    // Every output inverted, two passes, 3-bit counter saturates.
    flip_v[1] = 7'h7F;
    run_sweep("saturate", 1, 1, 2, 7, -1);
    flip_v[1] = '0;

    // Start re-pulsed mid-sweep is ignored.
    run_sweep("start_ignored", 0, 1, 1, 255, 3);

    // Reset in cycle 5 of a faulty sweep.
    flip_v[0] = 7'h7F;
    @(negedge clk) start_v[0] = 1'b1;
    @(negedge clk) start_v[0] = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", busy_v[0], 1);
    check("pre_reset_cnt", cnt_v[0], 14);
    rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_idle_zero("mid_reset", 0);
    flip_v[0] = '0;
    run_sweep("after_reset", 0, 1, 1, 255, -1);

    // Start held high: back-to-back sweeps, results cleared on restart.
    s0_v[2] = 7'b0000001;
    @(negedge clk) start_v[2] = 1'b1;
    @(negedge clk);
    k = 0;
    while (busy_v[2] && k < 200) begin k++; @(negedge clk); end
    check("b2b_busy_len1", k, 12);
    check("b2b_done1", done_v[2], 1);
    check("b2b_pass1", pass_v[2], 0);
    check("b2b_mask1", mask_v[2], 7'b0000001);
    check("b2b_cnt1", cnt_v[2], 1);
    s0_v[2] = '0;
    @(negedge clk);
    check("b2b_restart_busy", busy_v[2], 1);
    check("b2b_restart_done", done_v[2], 0);
    check("b2b_restart_mask", mask_v[2], 0);
    check("b2b_restart_cnt", cnt_v[2], 0);
    start_v[2] = 1'b0;
    k = 0;
    while (busy_v[2] && k < 200) begin k++; @(negedge clk); end
    check("b2b_busy_len2", k, 12);
    check("b2b_done2", done_v[2], 1);
    check("b2b_pass2", pass_v[2], 1);
    @(negedge clk);
    check("b2b_stop", busy_v[2], 0);

    // Randomized fault patterns against the model.
    for (int r = 0; r < 8; r++) begin
      flip_v[0] = 7'($urandom_range(0, 127) & $urandom_range(0, 127));
      s0_v[0]   = 7'($urandom_range(0, 127) & $urandom_range(0, 127) & $urandom_range(0, 127));
      s1_v[0]   = 7'($urandom_range(0, 127) & $urandom_range(0, 127) & $urandom_range(0, 127));
      if (r == 0) begin flip_v[0] = '0; s0_v[0] = '0; s1_v[0] = '0; end
      run_sweep("rand_a", 0, 1, 1, 255, -1);
    end
    for (int r = 0; r < 4; r++) begin
      flip_v[1] = 7'(1 << $urandom_range(0, 6));
      s0_v[1]   = '0;
      s1_v[1]   = 7'($urandom_range(0, 127) & $urandom_range(0, 127));
      run_sweep("rand_b", 1, 1, 2, 7, -1);
    end
    wait_idle(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
